// File: rtl/backup_mem_bram_if.sv
// Wide request/data/response channels between the memory deserializer
// (master) and the backup memory model (slave).
interface backup_mem_bram_if #(
   parameter int ADDR_BITS = 26,
   parameter int TAG_BITS  = 5,
   parameter int DATA_BITS = 128
);
   logic                 mem_req_valid;
   logic                 mem_req_ready;
   logic                 mem_req_rw;
   logic [ADDR_BITS-1:0] mem_req_addr;
   logic [TAG_BITS-1:0]  mem_req_tag;
   logic                 mem_req_data_valid;
   logic                 mem_req_data_ready;
   logic [DATA_BITS-1:0] mem_req_data_bits;
   logic                 mem_resp_valid;
   logic [DATA_BITS-1:0] mem_resp_data;
   logic [TAG_BITS-1:0]  mem_resp_tag;

   modport master (
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
      output mem_req_data_valid, mem_req_data_bits,
      input  mem_req_ready, mem_req_data_ready,
      input  mem_resp_valid, mem_resp_data, mem_resp_tag
   );

   modport slave (
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
      input  mem_req_data_valid, mem_req_data_bits,
      output mem_req_ready, mem_req_data_ready,
      output mem_resp_valid, mem_resp_data, mem_resp_tag
   );
endinterface

// File: rtl/backup_mem_bram.sv
// Block-RAM backup memory: one cache line (BEATS words) per request,
// registered read data, preloadable through the array named ram.
module backup_mem_bram #(
   parameter int ADDR_BITS     = 26,
   parameter int TAG_BITS      = 5,
   parameter int DATA_BITS     = 128,
   parameter int BEATS         = 4,
   parameter int LINE_IDX_BITS = 12
) (
   input  logic             htif_clk,
   input  logic             reset,
   backup_mem_bram_if.slave mem
);
   localparam int CNT_BITS = $clog2(BEATS);
   localparam int IDX_BITS = LINE_IDX_BITS + CNT_BITS;
   localparam int DEPTH    = 1 << IDX_BITS;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

   logic [DATA_BITS-1:0] ram [DEPTH];

   state_e                   state_q, state_d;
   logic [LINE_IDX_BITS-1:0] line_q, line_d;
   logic [TAG_BITS-1:0]      tag_q, tag_d;
   logic [CNT_BITS-1:0]      cnt_q, cnt_d;
   logic                     resp_valid_q, resp_valid_d;
   logic [TAG_BITS-1:0]      resp_tag_q, resp_tag_d;
   logic [DATA_BITS-1:0]     resp_data_q;

   logic                req_ready, data_ready;
   logic                req_fire, beat_fire, rd_en, last_beat;
   logic [IDX_BITS-1:0] idx;

   // Upper address bits are ignored on purpose: lines alias by wrap-around.
   logic unused_addr_bits;
   assign unused_addr_bits = ^mem.mem_req_addr[ADDR_BITS-1:LINE_IDX_BITS];

   assign req_ready  = (state_q == IDLE)  && !reset;
   assign data_ready = (state_q == WRITE) && !reset;
   assign req_fire   = mem.mem_req_valid && req_ready;
   assign beat_fire  = mem.mem_req_data_valid && data_ready;
   assign rd_en      = (state_q == READ) && !reset;
   assign last_beat  = (cnt_q == CNT_BITS'(BEATS - 1));
   assign idx        = {line_q, cnt_q};

   assign mem.mem_req_ready      = req_ready;
   assign mem.mem_req_data_ready = data_ready;
   assign mem.mem_resp_valid     = resp_valid_q;
   assign mem.mem_resp_data      = resp_data_q;
   assign mem.mem_resp_tag       = resp_tag_q;

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      tag_d        = tag_q;
      cnt_d        = cnt_q;
      resp_valid_d = rd_en;
      resp_tag_d   = rd_en ? tag_q : resp_tag_q;
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               line_d  = mem.mem_req_addr[LINE_IDX_BITS-1:0];
               tag_d   = mem.mem_req_tag;
               cnt_d   = '0;
               state_d = mem.mem_req_rw ? WRITE : READ;
            end
         end
         WRITE: begin
            if (beat_fire) begin
               cnt_d = CNT_BITS'(cnt_q + 1'b1);
               if (last_beat) state_d = IDLE;
            end
         end
         READ: begin
            // No backpressure on responses, so one beat issues every cycle.
            cnt_d = CNT_BITS'(cnt_q + 1'b1);
            if (last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge htif_clk) begin
      if (reset) begin
         state_q      <= IDLE;
         line_q       <= '0;
         tag_q        <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         tag_q        <= tag_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_tag_q   <= resp_tag_d;
      end
   end

   // Array itself is never reset so harness preload survives reset.
   always_ff @(posedge htif_clk) begin
      if (beat_fire) ram[idx] <= mem.mem_req_data_bits;
   end

   always_ff @(posedge htif_clk) begin
      if (reset)      resp_data_q <= '0;
      else if (rd_en) resp_data_q <= ram[idx];
   end
endmodule

// File: tb/tb_backup_mem_bram.sv
// Directed bench for backup_mem_bram: per-cycle vector table plus
// hand-written multi-cycle sequences (gaps, aliasing, back-to-back, reset).
module tb_backup_mem_bram;
   localparam int AB = 26, TB = 5, DB = 128, BEATS = 4, LIB = 12;

   logic htif_clk = 1'b0;
   logic reset;
   always #5 htif_clk = ~htif_clk;

   backup_mem_bram_if #(.ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB)) mif ();

   backup_mem_bram #(
      .ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB), .BEATS(BEATS), .LINE_IDX_BITS(LIB)
   ) dut (
      .htif_clk(htif_clk),
      .reset   (reset),
      .mem     (mif)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic          rst, rv, rw;
      logic [AB-1:0] addr;
      logic [TB-1:0] tag;
      logic          dv;
      logic [DB-1:0] db;
      logic          e_rdy, e_drdy, e_rv, chk_resp;
      logic [DB-1:0] e_rd;
      logic [TB-1:0] e_rt;
   } vec_t;
   vec_t tv[$];

   typedef logic [BEATS-1:0][DB-1:0] line_t;

   function automatic logic [DB-1:0] pre(int i);
      return {32'hDEAD_BEEF, 88'h0, 8'(i + 1)};
   endfunction

   function automatic logic [DB-1:0] wd(int s, int i);
      return {32'(s), 32'hA5A5_5A5A, 32'(i), 32'(s * 16 + i)};
   endfunction

   task automatic chk(string nm, logic [DB-1:0] act, logic [DB-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(logic rst, logic rv, logic rw, logic [AB-1:0] a, logic [TB-1:0] t,
                        logic dv, logic [DB-1:0] db);
      reset                  = rst;
      mif.mem_req_valid      = rv;
      mif.mem_req_rw         = rw;
      mif.mem_req_addr       = a;
      mif.mem_req_tag        = t;
      mif.mem_req_data_valid = dv;
      mif.mem_req_data_bits  = db;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic next();
      @(posedge htif_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge htif_clk);
   endtask

   task automatic add(logic rst, logic rv, logic rw, logic [AB-1:0] a, logic [TB-1:0] t,
                      logic dv, logic [DB-1:0] db, logic rdy, logic drdy, logic rvv,
                      logic cr, logic [DB-1:0] rd, logic [TB-1:0] rt);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rw = rw; v.addr = a; v.tag = t; v.dv = dv; v.db = db;
      v.e_rdy = rdy; v.e_drdy = drdy; v.e_rv = rvv; v.chk_resp = cr; v.e_rd = rd; v.e_rt = rt;
      tv.push_back(v);
   endtask

   task automatic write_line(logic [AB-1:0] a, line_t d);
      drive(1'b0, 1'b1, 1'b1, a, '0, 1'b0, '0);
      mid(); chk("wr_cmd_ready", mif.mem_req_ready, 1'b1);
      next();
      for (int i = 0; i < BEATS; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, d[i]);
         mid(); chk("wr_data_ready", mif.mem_req_data_ready, 1'b1);
         next();
      end
      idle();
      mid();
      chk("wr_done_ready", mif.mem_req_ready, 1'b1);
      chk("wr_done_data_ready", mif.mem_req_data_ready, 1'b0);
      next();
   endtask

   task automatic read_line(logic [AB-1:0] a, logic [TB-1:0] t, line_t e);
      drive(1'b0, 1'b1, 1'b0, a, t, 1'b0, '0);
      mid(); chk("rd_cmd_ready", mif.mem_req_ready, 1'b1);
      next();
      idle();
      mid(); chk("rd_lat_valid", mif.mem_resp_valid, 1'b0);
      next();
      for (int i = 0; i < BEATS; i++) begin
         mid();
         chk("rd_valid", mif.mem_resp_valid, 1'b1);
         chk("rd_data", mif.mem_resp_data, e[i]);
         chk("rd_tag", mif.mem_resp_tag, t);
         chk("rd_ready", mif.mem_req_ready, (i == BEATS - 1));
         next();
      end
      mid(); chk("rd_tail_valid", mif.mem_resp_valid, 1'b0);
      next();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before finish");
      $fatal(1, "watchdog");
   end

   initial begin
      line_t ln;
      drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < BEATS; i++) dut.ram[i] = pre(i);
      next();

      // Reset held 3 cycles with a command pending
      for (int i = 0; i < 3; i++) add(1,1,0,'0,'0,0,'0, 0,0,0, 1,'0,'0);
      // Preloaded read of line 0, tag 5
      add(0,1,0,'0,5,0,'0, 1,0,0, 0,'0,'0);
      add(0,0,0,'0,0,0,'0, 0,0,0, 0,'0,'0);
      for (int i = 0; i < BEATS; i++) add(0,0,0,'0,0,0,'0, (i == BEATS-1),0,1, 1,pre(i),5);
      // Continuous write of line 0x10, then read it back with tag 0x1F
      add(0,1,1,26'h10,0,0,'0, 1,0,0, 0,'0,'0);
      for (int i = 0; i < BEATS; i++) add(0,0,0,'0,0,1,wd(1,i), 0,1,0, 0,'0,'0);
      add(0,1,0,26'h10,5'h1F,1,wd(9,9), 1,0,0, 0,'0,'0);
      add(0,0,0,'0,0,0,'0, 0,0,0, 0,'0,'0);
      for (int i = 0; i < BEATS; i++) add(0,0,0,'0,0,0,'0, (i == BEATS-1),0,1, 1,wd(1,i),5'h1F);
      add(0,0,0,'0,0,0,'0, 1,0,0, 0,'0,'0);

      foreach (tv[n]) begin
         drive(tv[n].rst, tv[n].rv, tv[n].rw, tv[n].addr, tv[n].tag, tv[n].dv, tv[n].db);
         mid();
         chk($sformatf("v%0d_ready", n), mif.mem_req_ready, tv[n].e_rdy);
         chk($sformatf("v%0d_data_ready", n), mif.mem_req_data_ready, tv[n].e_drdy);
         chk($sformatf("v%0d_resp_valid", n), mif.mem_resp_valid, tv[n].e_rv);
         if (tv[n].chk_resp) begin
            chk($sformatf("v%0d_resp_data", n), mif.mem_resp_data, tv[n].e_rd);
            chk($sformatf("v%0d_resp_tag", n), mif.mem_resp_tag, tv[n].e_rt);
         end
         next();
      end

      // Gapped write to 0x1003 aliases line 3
      drive(1'b0, 1'b1, 1'b1, 26'h1003, '0, 1'b0, '0);
      mid(); chk("gap_cmd_ready", mif.mem_req_ready, 1'b1);
      next();
      for (int j = 0; j < 2 * BEATS; j++) begin
         if (j % 2 == 0) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, wd(2, j / 2));
         else            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, wd(7, 7));
         mid();
         chk($sformatf("gap%0d_data_ready", j), mif.mem_req_data_ready, (j <= 2 * BEATS - 2));
         chk($sformatf("gap%0d_ready", j), mif.mem_req_ready, (j == 2 * BEATS - 1));
         next();
      end
      idle();
      for (int i = 0; i < BEATS; i++) ln[i] = wd(2, i);
      read_line(26'h0003, 5'd3, ln);

      // Back-to-back reads: second command held valid through the first burst
      drive(1'b0, 1'b1, 1'b0, '0, 5'd7, 1'b0, '0);
      mid(); chk("b2b_cmd1_ready", mif.mem_req_ready, 1'b1);
      next();
      drive(1'b0, 1'b1, 1'b0, 26'h10, 5'd9, 1'b0, '0);
      for (int c = 1; c <= 10; c++) begin
         logic ev;
         ev = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
         mid();
         chk($sformatf("b2b%0d_valid", c), mif.mem_resp_valid, ev);
         chk($sformatf("b2b%0d_ready", c), mif.mem_req_ready, (c == 5 || c == 10));
         if (ev) begin
            chk($sformatf("b2b%0d_tag", c), mif.mem_resp_tag, (c <= 5) ? 5'd7 : 5'd9);
            chk($sformatf("b2b%0d_data", c), mif.mem_resp_data, (c <= 5) ? pre(c - 2) : wd(1, c - 7));
         end
         next();
         if (c == 5) idle();
      end

      // Reset after two read beats drops the rest of the burst
      drive(1'b0, 1'b1, 1'b0, '0, 5'd2, 1'b0, '0);
      mid(); chk("rrst_cmd_ready", mif.mem_req_ready, 1'b1);
      next();
      idle();
      next();
      mid(); chk("rrst_beat0", mif.mem_resp_data, pre(0));
      next();
      mid(); chk("rrst_beat1", mif.mem_resp_data, pre(1));
      reset = 1'b1;
      next();
      mid();
      chk("rrst_valid", mif.mem_resp_valid, 1'b0);
      chk("rrst_data", mif.mem_resp_data, '0);
      chk("rrst_tag", mif.mem_resp_tag, '0);
      chk("rrst_ready", mif.mem_req_ready, 1'b0);
      next();
      reset = 1'b0;
      mid();
      chk("rrst_rel_ready", mif.mem_req_ready, 1'b1);
      chk("rrst_rel_valid", mif.mem_resp_valid, 1'b0);
      next();
      mid(); chk("rrst_tail_valid", mif.mem_resp_valid, 1'b0);
      next();

      // Reset after two write beats keeps the committed half line
      for (int i = 0; i < BEATS; i++) ln[i] = wd(3, i);
      write_line(26'h20, ln);
      drive(1'b0, 1'b1, 1'b1, 26'h20, '0, 1'b0, '0);
      mid(); next();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, wd(4, i));
         mid(); chk("wrst_data_ready", mif.mem_req_data_ready, 1'b1);
         next();
      end
      drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, wd(4, 2));
      mid(); chk("wrst_rst_data_ready", mif.mem_req_data_ready, 1'b0);
      next();
      idle();
      mid();
      chk("wrst_rel_ready", mif.mem_req_ready, 1'b1);
      chk("wrst_rel_data_ready", mif.mem_req_data_ready, 1'b0);
      next();
      ln[0] = wd(4, 0); ln[1] = wd(4, 1);
      read_line(26'h20, 5'd1, ln);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/backup_mem_bram.md
# backup_mem_bram

Synchronous block-RAM model of the backup memory. It sits directly downstream of the narrow-to-wide memory deserializer in the test harness and serves that block's wide request/data/response channels on the HTIF clock. Each request moves one cache line: reads return BEATS consecutive response beats, writes absorb BEATS data beats. The array is preloadable from the harness (`loadmem`) through the hierarchical name `ram`.

## Interface
- ADDR_BITS, 26, line address width (byte address = {addr, 6'd0})
- TAG_BITS, 5, request/response tag width
- DATA_BITS, 128, beat width
- BEATS, 4, beats per line (power of two, ≥2)
- LINE_IDX_BITS, 12, line-index bits actually decoded; array depth = 2^LINE_IDX_BITS × BEATS words of DATA_BITS, named `ram`

Ports:
- htif_clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clock htif_clk
- mem_req_valid  in  1  command valid
- mem_req_ready  out  1  command accepted when valid & ready
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_addr  in  ADDR_BITS  line address
- mem_req_tag  in  TAG_BITS  tag echoed on read responses
- mem_req_data_valid  in  1  write beat valid
- mem_req_data_ready  out  1  write beat accepted when valid & ready
- mem_req_data_bits  in  DATA_BITS  write beat
- mem_resp_valid  out  1  read beat valid; no backpressure, consumer always accepts
- mem_resp_data  out  DATA_BITS  read beat
- mem_resp_tag  out  TAG_BITS  tag of the originating read

## Operation
- States: IDLE, WRITE, READ. Registers: line (LINE_IDX_BITS), tag, cnt (log2 BEATS).
- Only addr[LINE_IDX_BITS-1:0] is decoded. Upper bits are ignored, so accesses alias by wrap-around. No error is reported.
- Word index = {line, cnt}.
- IDLE: mem_req_ready = 1. On accept, latch line and tag, and set cnt = 0. Go to WRITE if rw = 1, else READ.
- WRITE: mem_req_data_ready = 1; mem_req_ready = 0.
  - Each accepted beat writes ram[{line,cnt}] at that edge and increments cnt.
  - Gaps between beats (data_valid low) are allowed and hold state.
  - The beat with cnt = BEATS-1 returns the block to IDLE.
- READ: mem_req_ready = 0.
  - Each cycle issues a synchronous read of ram[{line,cnt}] and increments cnt.
  - After the read with cnt = BEATS-1 issues, go to IDLE.
  - Read data is registered, and mem_resp_valid/tag are pipelined with it.
- Data beats presented in IDLE or READ are not accepted (data_ready = 0). The deserializer holds them.
- mem_req_ready = (state==IDLE) & !reset. mem_req_data_ready = (state==WRITE) & !reset.
- Reset: state goes to IDLE and cnt to 0. mem_resp_valid, mem_resp_data and mem_resp_tag go to 0. ram contents are not cleared, so preload survives reset.
- Reset mid-WRITE: partial line writes already committed remain. Reset mid-READ: pending beats are dropped and no further resp_valid is asserted.

## Timing
- Reset values: mem_req_ready 0, mem_req_data_ready 0, mem_resp_valid 0, mem_resp_data 0, mem_resp_tag 0. mem_req_ready is 1 in the first cycle after reset deasserts.
- Read: command accepted in cycle k.
  - Reads issue in cycles k+1..k+BEATS.
  - Beat i appears on mem_resp_* in cycle k+2+i.
  - mem_resp_valid is high for exactly BEATS consecutive cycles, k+2..k+1+BEATS.
  - Beats return in address order (cnt 0 first).
- IDLE re-entered in cycle k+1+BEATS, so mem_req_ready is high concurrently with the last read beat.
  - Back-to-back reads: the second command is accepted at cycle k+1+BEATS and its first beat appears at k+3+BEATS. Responses never overlap.
- Write: command accepted in cycle k, so mem_req_data_ready goes high in cycle k+1. With continuous data, beats are accepted in k+1..k+BEATS and IDLE is re-entered at k+BEATS+1.
- Write data is visible to any read command accepted in the cycle after the last write beat or later.
- Command and data are never accepted in the same cycle.

## Test plan
- Reset: hold reset 3 cycles with req_valid=1 -> ready=0, data_ready=0, resp_valid=0 throughout. ready=1 in the first cycle after release.
- Preload + read: $readmemh ram word 0..3 = 0x…01..0x…04; read addr 0, tag 5 -> resp_valid in 4 consecutive cycles starting 2 cycles after accept, data 01,02,03,04, tag 5 on every beat.
- Write then read: write addr 0x10 with beats A0,A1,A2,A3 (continuous), then read addr 0x10, tag 0x1F -> read beats A0..A3 with tag 0x1F. Total latency from write accept to first read beat = 4+1+2 cycles.
- Gapped write + aliasing: write addr 0x1003 (LINE_IDX_BITS=12) with data_valid toggling every other cycle -> exactly 4 beats accepted, no early return to IDLE. Reading addr 0x0003 returns the same 4 beats.
- Back-to-back reads: a second read request held valid across the first -> accepted in the same cycle as the first request's last beat. resp_valid shows 4 high, 1 low, 4 high; tags are correct per burst.
- Reset mid-operation: assert reset after 2 of 4 read beats -> resp_valid 0 from the next cycle, no residual beats, ready=1 after release. Assert reset after 2 write beats -> those 2 words are updated and the other 2 keep their old values.
